// File: rtl/bp_table_sched_pkg.sv
// Shared types for the branch predictor table scheduler: entry layout,
// queued update record, scheduler states and the 2-bit counter update rule.
package bp_pkg;

   localparam int XLEN  = 32;
   localparam int TAG_W = 3;
   localparam int N_ENT = 1 << TAG_W;

   localparam logic [1:0] CTR_WEAK_T  = 2'b10;
   localparam logic [1:0] CTR_WEAK_NT = 2'b01;

   typedef struct packed {
      logic [XLEN-1:0] target;
      logic [1:0]      ctr;
      logic            valid;
   } bp_entry_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             taken;
      logic [XLEN-1:0]  target;
   } bp_upd_t;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_UPD_RD = 2'd2,
      ST_UPD_WR = 2'd3
   } bp_sched_state_e;

   // New entry after a resolved branch: first touch seeds a weak counter,
   // later touches saturate; target only follows taken branches.
   function automatic bp_entry_t bp_apply_upd(input bp_entry_t old_e, input bp_upd_t upd);
      bp_entry_t new_e;
      new_e       = old_e;
      new_e.valid = 1'b1;
      if (!old_e.valid) begin
         new_e.ctr    = upd.taken ? CTR_WEAK_T : CTR_WEAK_NT;
         new_e.target = upd.target;
      end else if (upd.taken) begin
         new_e.ctr    = (old_e.ctr == 2'b11) ? 2'b11 : old_e.ctr + 2'b01;
         new_e.target = upd.target;
      end else begin
         new_e.ctr    = (old_e.ctr == 2'b00) ? 2'b00 : old_e.ctr - 2'b01;
      end
      return new_e;
   endfunction

endpackage

// File: rtl/bp_table_sched_if.sv
// Bundle of IFU lookup, EXU update, flush and table-port signals.
// slave = scheduler side, master = environment side.
interface bp_table_sched_if;
   import bp_pkg::*;

   logic                ifu_req_valid;
   logic [TAG_W-1:0]    ifu_req_tag;
   logic                ifu_req_ready;
   logic                ifu_rsp_valid;
   logic                ifu_rsp_dir;
   logic [XLEN-1:0]     ifu_rsp_target;
   logic                exu_upd_valid;
   logic                exu_upd_ready;
   logic [TAG_W-1:0]    exu_upd_tag;
   logic                exu_upd_taken;
   logic [XLEN-1:0]     exu_upd_target;
   logic                flush_req;
   logic                tbl_en;
   logic                tbl_we;
   logic [TAG_W-1:0]    tbl_addr;
   logic [XLEN+2:0]     tbl_wdata;
   logic [XLEN+2:0]     tbl_rdata;
   logic                init_busy;

   modport slave (
      input  ifu_req_valid, ifu_req_tag, exu_upd_valid, exu_upd_tag, exu_upd_taken,
             exu_upd_target, flush_req, tbl_rdata,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_dir, ifu_rsp_target, exu_upd_ready,
             tbl_en, tbl_we, tbl_addr, tbl_wdata, init_busy
   );

   modport master (
      output ifu_req_valid, ifu_req_tag, exu_upd_valid, exu_upd_tag, exu_upd_taken,
             exu_upd_target, flush_req, tbl_rdata,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_dir, ifu_rsp_target, exu_upd_ready,
             tbl_en, tbl_we, tbl_addr, tbl_wdata, init_busy
   );

endinterface

// File: rtl/bp_table_sched_upd_fifo.sv
// Synchronous FIFO of pending branch updates with a synchronous clear.
module bp_upd_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    clr_i,
   input  logic    push_i,
   input  bp_upd_t push_data_i,
   input  logic    pop_i,
   output bp_upd_t head_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   bp_upd_t          mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Extra pointer bit tells full from empty when the indices coincide.
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok_s = push_i & ~full_o & ~clr_i;
   assign pop_ok_s  = pop_i & ~empty_o & ~clr_i;
   assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values; clear dominates push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
   end

   // Pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care while empty so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/bp_table_sched.sv
// Arbitrates the single predictor-table port between IFU lookups and
// buffered EXU updates (read-modify-write), and clears the table after
// reset or flush.
module bp_table_sched
   import bp_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   bp_table_sched_if.slave        bus
);

   localparam int               SC_W       = $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
   localparam logic [TAG_W-1:0] LAST_IDX   = TAG_W'(N_ENT - 1);

   bp_sched_state_e  state_q;
   logic [TAG_W-1:0] clear_idx_q;
   logic [SC_W-1:0]  starve_cnt_q;
   logic             flushing_q;
   logic             flush_pend_q;
   logic             rsp_valid_q;

   bp_upd_t          head_s;
   bp_upd_t          push_data_s;
   bp_entry_t        old_entry_s;
   bp_entry_t        new_entry_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             update_wins_s;
   logic             ifu_grant_s;
   logic             upd_ready_s;
   logic             push_s;
   logic             pop_s;

   // A flush cycle never starts an update: the FIFO is being cleared.
   assign update_wins_s = (state_q == ST_IDLE) & ~fifo_empty_s & ~bus.flush_req &
                          (~bus.ifu_req_valid | (starve_cnt_q == STARVE_LIM));
   assign bus.ifu_req_ready = rst_n & (state_q == ST_IDLE) & ~update_wins_s;
   assign ifu_grant_s       = bus.ifu_req_ready & bus.ifu_req_valid;
   assign upd_ready_s       = rst_n & ~fifo_full_s & ~bus.flush_req & ~flushing_q;
   assign bus.exu_upd_ready = upd_ready_s;
   assign push_s            = bus.exu_upd_valid & upd_ready_s;
   assign pop_s             = rst_n & (state_q == ST_UPD_RD);
   assign push_data_s       = '{tag: bus.exu_upd_tag, taken: bus.exu_upd_taken,
                                target: bus.exu_upd_target};

   assign old_entry_s        = bp_entry_t'(bus.tbl_rdata);
   assign new_entry_s        = bp_apply_upd(old_entry_s, head_s);
   assign bus.ifu_rsp_valid  = rsp_valid_q;
   assign bus.ifu_rsp_dir    = old_entry_s.valid & old_entry_s.ctr[1];
   assign bus.ifu_rsp_target = old_entry_s.target;
   assign bus.init_busy      = ~rst_n | (state_q == ST_INIT);

   bp_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (bus.flush_req),
      .push_i      (push_s),
      .push_data_i (push_data_s),
      .pop_i       (pop_s),
      .head_o      (head_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s)
   );

   // Table port drive for the current state; idle during reset.
   always_comb begin
      bus.tbl_en    = 1'b0;
      bus.tbl_we    = 1'b0;
      bus.tbl_addr  = '0;
      bus.tbl_wdata = '0;
      if (!rst_n) begin
         bus.tbl_en = 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               bus.tbl_en   = 1'b1;
               bus.tbl_we   = 1'b1;
               bus.tbl_addr = clear_idx_q;
            end
            ST_IDLE: begin
               if (update_wins_s) begin
                  bus.tbl_en   = 1'b1;
                  bus.tbl_addr = head_s.tag;
               end else if (bus.ifu_req_valid) begin
                  bus.tbl_en   = 1'b1;
                  bus.tbl_addr = bus.ifu_req_tag;
               end else begin
                  bus.tbl_en = 1'b0;
               end
            end
            ST_UPD_RD: begin
               bus.tbl_en    = 1'b1;
               bus.tbl_we    = 1'b1;
               bus.tbl_addr  = head_s.tag;
               bus.tbl_wdata = new_entry_s;
            end
            ST_UPD_WR: begin
               bus.tbl_en = 1'b0;
            end
            default: begin
               bus.tbl_en = 1'b0;
            end
         endcase
      end
   end

   // Scheduler FSM with clear index, starvation counter and response pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         clear_idx_q  <= '0;
         starve_cnt_q <= '0;
         flushing_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
      end else begin
         rsp_valid_q <= ifu_grant_s;

         if (bus.flush_req) begin
            flushing_q <= 1'b1;
         end else if ((state_q == ST_INIT) && (clear_idx_q == LAST_IDX)) begin
            flushing_q <= 1'b0;
         end else begin
            flushing_q <= flushing_q;
         end

         if (fifo_empty_s || update_wins_s) begin
            starve_cnt_q <= '0;
         end else if (ifu_grant_s && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_q <= starve_cnt_q + SC_W'(1);
         end else begin
            starve_cnt_q <= starve_cnt_q;
         end

         case (state_q)
            ST_INIT: begin
               if (bus.flush_req) begin
                  clear_idx_q <= '0;
               end else if (clear_idx_q == LAST_IDX) begin
                  clear_idx_q <= '0;
                  state_q     <= ST_IDLE;
               end else begin
                  clear_idx_q <= clear_idx_q + TAG_W'(1);
               end
            end
            ST_IDLE: begin
               if (bus.flush_req) begin
                  state_q <= ST_INIT;
               end else if (update_wins_s) begin
                  state_q <= ST_UPD_RD;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_UPD_RD: begin
               flush_pend_q <= bus.flush_req;
               state_q      <= ST_UPD_WR;
            end
            ST_UPD_WR: begin
               flush_pend_q <= 1'b0;
               if (flush_pend_q || bus.flush_req) begin
                  state_q <= ST_INIT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bp_table_sched.sv
// Scoreboard bench for bp_table_sched: a behavioural RAM answers the table
// port, a reference predictor table predicts every write and every lookup.
module tb_bp_table_sched;
   import bp_pkg::*;

   logic clk;
   logic rst_n;

   bp_table_sched_if bus ();

   bp_table_sched #(.FIFO_DEPTH(4), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM with 1-cycle read latency.
   logic [XLEN+2:0] ram [N_ENT];
   always @(posedge clk) begin
      if (bus.tbl_en) begin
         if (bus.tbl_we) ram[bus.tbl_addr] <= bus.tbl_wdata;
         else            bus.tbl_rdata     <= ram[bus.tbl_addr];
      end
   end

   typedef struct { int tag; bit taken; logic [31:0] tgt; } upd_s;
   typedef struct { bit dir; logic [31:0] tgt; int cyc; } rsp_s;

   upd_s        upd_q[$];
   rsp_s        rsp_q[$];
   int          ref_ctr [N_ENT];
   bit          ref_vld [N_ENT];
   logic [31:0] ref_tgt [N_ENT];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          exp_clr, init_len;
   bit          init_prev, flushing;
   logic [34:0] last_wr;
   int          n_upd_wr = 0;
   bit          last_dir;
   logic [31:0] last_tgt;
   int          g_cnt, s_cnt, wr_base;
   bit          seen_stall;
   int          sat_exp [8] = '{2, 3, 3, 3, 2, 1, 0, 0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor / scoreboard: samples everything on the falling edge.
   always @(negedge clk) begin
      upd_s        u;
      rsp_s        r;
      int          c;
      logic [31:0] t;
      logic [34:0] e;
      int          tg;
      cyc++;
      if (!rst_n) begin
         upd_q.delete(); rsp_q.delete();
         exp_clr = 0; init_len = 0; init_prev = 0; flushing = 0;
      end else begin
         if (bus.tbl_en && bus.tbl_we) begin
            if (bus.init_busy) begin
               chk("init_addr", bus.tbl_addr, exp_clr % N_ENT);
               chk("init_data", bus.tbl_wdata, 0);
               ref_vld[exp_clr % N_ENT] = 0; ref_ctr[exp_clr % N_ENT] = 0;
               ref_tgt[exp_clr % N_ENT] = 0;
               exp_clr++;
            end else if (upd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL upd_unexpected: write addr %0d with no queued update", bus.tbl_addr);
            end else begin
               u = upd_q.pop_front();
               if (!ref_vld[u.tag]) begin
                  c = u.taken ? 2 : 1; t = u.tgt;
               end else begin
                  c = ref_ctr[u.tag]; t = ref_tgt[u.tag];
                  if (u.taken) begin c = (c < 3) ? c + 1 : 3; t = u.tgt; end
                  else         c = (c > 0) ? c - 1 : 0;
               end
               e = {t, c[1:0], 1'b1};
               chk("upd_addr", bus.tbl_addr, u.tag);
               chk("upd_wdata", bus.tbl_wdata, e);
               ref_vld[u.tag] = 1; ref_ctr[u.tag] = c; ref_tgt[u.tag] = t;
               last_wr = bus.tbl_wdata;
               n_upd_wr++;
            end
         end
         if (bus.ifu_rsp_valid) begin
            if (rsp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rsp_unexpected: response with no outstanding grant");
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_latency", cyc - r.cyc, 1);
               chk("rsp_dir", bus.ifu_rsp_dir, r.dir);
               chk("rsp_target", bus.ifu_rsp_target, r.tgt);
               last_dir = bus.ifu_rsp_dir; last_tgt = bus.ifu_rsp_target;
            end
         end
         if (bus.init_busy && bus.ifu_req_valid) chk("ready_in_init", bus.ifu_req_ready, 0);
         if (bus.ifu_req_valid && bus.ifu_req_ready) begin
            tg = int'(bus.ifu_req_tag);
            r.dir = ref_vld[tg] && (ref_ctr[tg] >= 2);
            r.tgt = ref_tgt[tg];
            r.cyc = cyc;
            rsp_q.push_back(r);
         end
         if (bus.init_busy) init_len++;
         else if (init_prev) begin
            chk("init_len", init_len, N_ENT);
            init_len = 0; flushing = 0;
         end
         init_prev = bus.init_busy;
         if (bus.flush_req) begin
            chk("flush_upd_ready", bus.exu_upd_ready, 0);
            upd_q.delete(); exp_clr = 0; init_len = 0; flushing = 1;
         end else if (flushing) begin
            chk("flushing_upd_ready", bus.exu_upd_ready, 0);
         end
         if (bus.exu_upd_valid && bus.exu_upd_ready) begin
            u.tag = int'(bus.exu_upd_tag); u.taken = bus.exu_upd_taken; u.tgt = bus.exu_upd_target;
            upd_q.push_back(u);
         end
      end
   end

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   task automatic push_upd(input int tag, input bit taken, input logic [31:0] tgt);
      bit acc = 0;
      bus.exu_upd_valid = 1'b1; bus.exu_upd_tag = TAG_W'(tag);
      bus.exu_upd_taken = taken; bus.exu_upd_target = tgt;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clk); acc = bus.exu_upd_ready;
         cycle();
      end
      bus.exu_upd_valid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL push_timeout: update tag %0d never accepted", tag);
      end
   endtask

   task automatic lookup(input int tag);
      bit gnt = 0;
      bus.ifu_req_valid = 1'b1; bus.ifu_req_tag = TAG_W'(tag);
      for (int k = 0; k < 100 && !gnt; k++) begin
         @(negedge clk); gnt = bus.ifu_req_ready;
         cycle();
      end
      bus.ifu_req_valid = 1'b0;
      if (!gnt) begin
         checks++; errors++;
         $display("FAIL lookup_timeout: tag %0d never granted", tag);
      end
      cycle();
   endtask

   task automatic drain();
      bit done = 0;
      for (int k = 0; k < 1000 && !done; k++) begin
         cycle();
         done = (upd_q.size() == 0) && (rsp_q.size() == 0) && !bus.init_busy;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL drain_timeout: upd_q=%0d rsp_q=%0d", upd_q.size(), rsp_q.size());
      end
      repeat (3) cycle();
   endtask

   initial begin
      for (int i = 0; i < N_ENT; i++) ram[i] = {$urandom(), 3'b111};
      bus.tbl_rdata = '0;
      bus.ifu_req_valid = 1'b1; bus.ifu_req_tag = '0;
      bus.exu_upd_valid = 1'b0; bus.exu_upd_tag = '0; bus.exu_upd_taken = 1'b0;
      bus.exu_upd_target = '0; bus.flush_req = 1'b0;
      rst_n = 1'b0;

      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_init_busy", bus.init_busy, 1);
      chk("rst_tbl_en", bus.tbl_en, 0);
      chk("rst_tbl_we", bus.tbl_we, 0);
      chk("rst_rsp_valid", bus.ifu_rsp_valid, 0);
      chk("rst_req_ready", bus.ifu_req_ready, 0);
      cycle();
      rst_n = 1'b1;

      // Release: IFU held valid through the clear walk.
      repeat (12) cycle();
      bus.ifu_req_valid = 1'b0;
      drain();

      // Update then lookup.
      push_upd(5, 1'b1, 32'h0000_1000);
      drain();
      chk("upd5_wdata", last_wr, {32'h0000_1000, 2'b10, 1'b1});
      lookup(5);
      chk("lkp5_dir", last_dir, 1);
      chk("lkp5_tgt", last_tgt, 32'h0000_1000);

      // Saturation on tag 2.
      for (int i = 0; i < 8; i++) begin
         push_upd(2, (i < 4), (i < 4) ? 32'h2000 + i : 32'hBAD0 + i);
         drain();
         chk("sat_ctr", last_wr[2:1], sat_exp[i]);
         chk("sat_tgt", last_wr[34:3], (i < 4) ? 32'h2000 + i : 32'h2003);
         lookup(2);
         chk("sat_dir", last_dir, (sat_exp[i] >= 2));
      end

      // Starvation: one queued update against a continuous IFU stream.
      bus.ifu_req_valid = 1'b1; bus.ifu_req_tag = 3'd1;
      repeat (3) cycle();
      push_upd(6, 1'b1, 32'h3000);
      g_cnt = 0; s_cnt = 0; seen_stall = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (!seen_stall) begin
            if (bus.ifu_req_ready) g_cnt++;
            else begin seen_stall = 1; s_cnt = 1; end
         end else begin
            if (bus.ifu_req_ready) break;
            s_cnt++;
         end
      end
      cycle();
      chk("starve_grants", g_cnt, 4);
      chk("starve_stall", s_cnt, 3);
      bus.ifu_req_valid = 1'b0;
      drain();

      // FIFO full: four accepted, fifth refused, all applied in order.
      wr_base = n_upd_wr;
      bus.ifu_req_valid = 1'b1; bus.ifu_req_tag = 3'd4;
      for (int i = 0; i < 5; i++) begin
         bus.exu_upd_valid = 1'b1; bus.exu_upd_tag = TAG_W'(i + 1);
         bus.exu_upd_taken = i[0]; bus.exu_upd_target = 32'h4000 + i;
         @(negedge clk);
         chk("fifo_accept", bus.exu_upd_ready, (i < 4));
         cycle();
      end
      bus.exu_upd_valid = 1'b0; bus.ifu_req_valid = 1'b0;
      drain();
      chk("fifo_applied", n_upd_wr - wr_base, 4);

      // Flush while in UPD_RD with a second update queued.
      wr_base = n_upd_wr;
      bus.exu_upd_valid = 1'b1; bus.exu_upd_tag = 3'd3;
      bus.exu_upd_taken = 1'b1; bus.exu_upd_target = 32'h5000;
      cycle();
      bus.exu_upd_tag = 3'd7; bus.exu_upd_target = 32'h5007;
      cycle();
      bus.exu_upd_valid = 1'b0; bus.flush_req = 1'b1;
      @(negedge clk);
      chk("flush_in_upd_rd", bus.tbl_we && !bus.init_busy, 1);
      cycle();
      bus.flush_req = 1'b0;
      drain();
      chk("flush_applied", n_upd_wr - wr_base, 1);
      for (int i = 0; i < N_ENT; i++) begin
         lookup(i);
         chk("post_flush_dir", last_dir, 0);
         chk("post_flush_tgt", last_tgt, 0);
      end

      // Random traffic with occasional flushes.
      for (int k = 0; k < 600; k++) begin
         bus.ifu_req_valid  = 1'($urandom_range(0, 1));
         bus.ifu_req_tag    = TAG_W'($urandom_range(0, N_ENT - 1));
         bus.exu_upd_valid  = ($urandom_range(0, 9) < 4);
         bus.exu_upd_tag    = TAG_W'($urandom_range(0, N_ENT - 1));
         bus.exu_upd_taken  = 1'($urandom_range(0, 1));
         bus.exu_upd_target = $urandom();
         bus.flush_req      = ($urandom_range(0, 63) == 0);
         cycle();
      end
      bus.ifu_req_valid = 1'b0; bus.exu_upd_valid = 1'b0; bus.flush_req = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bp_table_sched.md
Name: bp_table_sched

Overview:
- Scheduler and sequencer for the 2-bit branch predictor table, modelled as a single-port synchronous RAM with 1-cycle read latency.
- Arbitrates the one table port between IFU prediction lookups and EXU resolution updates.
- EXU updates are buffered in a small FIFO and applied by read-modify-write, which performs the saturating 2-bit counter math.
- Runs a clear sequence after reset and after flush, walking every entry.

Parameters:
- XLEN, 32, width of branch target.
- TAG_W, 3, table index width; entries N = 2**TAG_W.
- FIFO_DEPTH, 4, update FIFO depth (power of 2, >=2).
- STARVE_MAX, 4, consecutive cycles IFU may block a pending update before the update wins.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ifu_req_valid  in  1  lookup request
- ifu_req_tag  in  TAG_W  lookup index
- ifu_req_ready  out  1  lookup granted this cycle
- ifu_rsp_valid  out  1  lookup result valid (1 cycle after grant)
- ifu_rsp_dir  out  1  predicted taken = entry.valid & entry.ctr[1]
- ifu_rsp_target  out  XLEN  entry.target
- exu_upd_valid  in  1  branch resolved
- exu_upd_ready  out  1  = FIFO not full and not flushing
- exu_upd_tag  in  TAG_W  branch index
- exu_upd_taken  in  1  resolved direction
- exu_upd_target  in  XLEN  resolved target
- flush_req  in  1  single-cycle pulse: clear table and FIFO
- tbl_en  out  1  port enable
- tbl_we  out  1  write enable
- tbl_addr  out  TAG_W  port address
- tbl_wdata  out  XLEN+3  {target, ctr[1:0], valid}
- tbl_rdata  in  XLEN+3  read data, valid the cycle after tbl_en & !tbl_we
- init_busy  out  1  clear sequence in progress

Behaviour:
- Reset values:
  - FSM enters INIT with clear index 0; FIFO is emptied; starve_cnt = 0.
  - init_busy = 1; ifu_rsp_valid = 0; tbl_en = tbl_we = 0 during the reset cycle.
- FSM states: INIT, IDLE, UPD_RD, UPD_WR.
- INIT:
  - Each cycle writes 0 to entry clear_idx (tbl_en = tbl_we = 1), then increments clear_idx.
  - After writing entry N-1, goes to IDLE and drops init_busy. INIT lasts exactly N cycles.
  - ifu_req_ready = 0 throughout; exu_upd_ready still follows FIFO fullness, so pushes are accepted.
- IDLE, grant rule:
  - update_wins = FIFO non-empty & (!ifu_req_valid | starve_cnt == STARVE_MAX).
  - ifu_req_ready = (state == IDLE) & !update_wins.
- IDLE, IFU grant:
  - tbl_en = 1, tbl_we = 0, tbl_addr = ifu_req_tag.
  - Next cycle: ifu_rsp_valid = 1 with dir/target decoded from tbl_rdata. ifu_rsp_valid is a registered 1-cycle pulse per grant.
- IDLE, update wins:
  - Read FIFO head tag (tbl_en = 1, tbl_we = 0), go to UPD_RD; starve_cnt clears to 0.
- UPD_RD:
  - tbl_rdata is available; compute the new entry; drive the write (tbl_en = tbl_we = 1, same tag).
  - Pop the FIFO; go to UPD_WR.
- UPD_WR:
  - One bubble cycle; port idle; ifu_req_ready = 0; return to IDLE.
  - A full update therefore occupies 3 cycles: IDLE grant, UPD_RD, UPD_WR.
- Entry update rules:
  - If old entry is invalid: ctr = taken ? 2'b10 : 2'b01, target = exu target, valid = 1.
  - Else: ctr saturating (taken: min(3, ctr+1); not taken: max(0, ctr-1)); target replaced only when taken; valid stays 1.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each IDLE cycle where the FIFO is non-empty and the IFU is granted.
  - Clears when an update wins or the FIFO is empty.
- FIFO:
  - Push when exu_upd_valid & exu_upd_ready.
  - Push and pop in the same cycle is legal; count unchanged.
  - Full means exu_upd_ready = 0.
- Same-tag hazard: an IFU read of a tag that is mid-update returns the old (pre-write) value. This is accepted; no forwarding.
- flush_req:
  - The FIFO is cleared and any push in the same cycle is dropped. exu_upd_ready = 0 from the flush cycle until INIT ends.
  - If in UPD_RD, the write completes first; INIT begins after UPD_WR. From IDLE or INIT, go to INIT with clear_idx = 0 next cycle.
  - An IFU grant issued in the flush cycle still produces its ifu_rsp_valid.
- rst_n asserted mid-operation: abort immediately, return to reset values; no partial write is completed.

Decomposition:
- Shared package bp_pkg holds:
  - bp_entry_t packed struct {target[XLEN-1:0], ctr[1:0], valid}.
  - bp_upd_t {tag, taken, target}.
  - FSM enum bp_sched_state_e.
  - Counter constants CTR_WEAK_T = 2'b10, CTR_WEAK_NT = 2'b01.
- One sub-module: bp_upd_fifo, a parameterised synchronous FIFO of bp_upd_t with push/pop/full/empty and a synchronous clear.

Test Plan:
- Reset release:
  - init_busy = 1 for exactly 8 cycles (TAG_W = 3) with writes of 0 to addresses 0..7 in order, then 0.
  - ifu_req_ready = 0 during that window.
- Update then lookup:
  - After init, push {tag 5, taken, 0x1000}.
  - Entry 5 is written with {0x1000, 2'b10, 1}.
  - IFU lookup of tag 5 returns dir = 1, target 0x1000 exactly one cycle after the grant.
- Saturation:
  - Push tag 2 taken 4 times: ctr goes 10, 11, 11, 11.
  - Then not taken 4 times: ctr goes 10, 01, 00, 00. dir flips to 0 after the second not-taken.
  - The target is unchanged by not-taken updates.
- Starvation:
  - ifu_req_valid held high continuously with 1 update queued: IFU granted exactly 4 cycles.
  - The update then wins: ifu_req_ready = 0 for 3 cycles, after which IFU grants resume.
- FIFO full:
  - Push 4 updates while ifu_req_valid is held high and starve_cnt is below the limit.
  - exu_upd_ready drops to 0 and a 5th valid is not accepted.
  - All 4 updates are later applied in push order.
- Flush in UPD_RD with 2 updates queued:
  - The current write completes; the FIFO empties; INIT runs 8 cycles.
  - A subsequent lookup of any tag returns dir = 0, target 0.
